// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage and the decoder: FSM encoding,
// reset PC default and base opcodes.
package rv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_TRAP = 2'd3;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_B    = 7'b1100011;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch and memory.
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             Imem_Req_o;
    logic [WIDTH-1:0] Imem_Addr_o;
    logic [WIDTH-1:0] Imem_Rdata_i;
    logic             Imem_Rvalid_i;

    modport master (
        output Imem_Req_o,
        output Imem_Addr_o,
        input  Imem_Rdata_i,
        input  Imem_Rvalid_i
    );

    modport slave (
        input  Imem_Req_o,
        input  Imem_Addr_o,
        output Imem_Rdata_i,
        output Imem_Rvalid_i
    );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: JALR > JAL > taken branch > sequential, with JALR
// bit-0 clear and word-misalignment detection on the chosen target.
module next_pc_sel #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             branch_taken,
    input  logic             jal,
    input  logic             jalr,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jalr_target,
    output logic [WIDTH-1:0] next_pc,
    output logic             misaligned
);

    always_comb begin
        next_pc = pc + WIDTH'(4);
        if (jalr) begin
            next_pc = jalr_target & ~WIDTH'(1);
        end else if (jal || branch_taken) begin
            next_pc = branch_target;
        end
        misaligned = |next_pc[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction
// over the imem channel and holds it for decode until retired.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall_i,
    input  logic              Branch_Taken_i,
    input  logic              Jal_i,
    input  logic              JalR_i,
    input  logic [WIDTH-1:0]  Branch_Target_i,
    input  logic [WIDTH-1:0]  JalR_Target_i,
    fetch_unit_if.master      imem,
    output logic [WIDTH-1:0]  Instr_o,
    output logic              Instr_Valid_o,
    output logic [WIDTH-1:0]  PC_o,
    output logic [WIDTH-1:0]  PC_Plus4_o,
    output logic              Misaligned_o
);

    logic [1:0]       state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] next_pc;
    logic             next_misaligned;

    next_pc_sel #(.WIDTH(WIDTH)) u_next_pc_sel (
        .pc            (pc_q),
        .branch_taken  (Branch_Taken_i),
        .jal           (Jal_i),
        .jalr          (JalR_i),
        .branch_target (Branch_Target_i),
        .jalr_target   (JalR_Target_i),
        .next_pc       (next_pc),
        .misaligned    (next_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_REQ;
                ST_REQ: begin
                    if (imem.Imem_Rvalid_i) begin
                        instr_q <= imem.Imem_Rdata_i;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A misaligned target is still latched so the trap handler sees it.
                    if (!Stall_i) begin
                        pc_q  <= next_pc;
                        state <= next_misaligned ? ST_TRAP : ST_REQ;
                    end
                end
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_BOOT;
            endcase
        end
    end

    assign imem.Imem_Req_o  = (state == ST_REQ);
    assign imem.Imem_Addr_o = pc_q;
    assign Instr_o          = instr_q;
    assign Instr_Valid_o    = (state == ST_HOLD);
    assign Misaligned_o     = (state == ST_TRAP);
    assign PC_o             = pc_q;
    assign PC_Plus4_o       = pc_q + WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// redirect/latency/stall traffic compared against a PC-sequence model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk;
    logic        reset, rst2;
    logic        stall, br, jal, jalr;
    logic [31:0] bt, jt;
    logic [31:0] instr, pc, pc4, instr2, pc2, pc42;
    logic        ivalid, mis, ivalid2, mis2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;

    fetch_unit_if #(.WIDTH(32)) mif ();
    fetch_unit_if #(.WIDTH(32)) mif2 ();

    fetch_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Stall_i(stall), .Branch_Taken_i(br),
        .Jal_i(jal), .JalR_i(jalr), .Branch_Target_i(bt), .JalR_Target_i(jt),
        .imem(mif.master), .Instr_o(instr), .Instr_Valid_o(ivalid),
        .PC_o(pc), .PC_Plus4_o(pc4), .Misaligned_o(mis)
    );

    fetch_unit #(.WIDTH(32), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .reset(rst2), .Stall_i(1'b0), .Branch_Taken_i(1'b0),
        .Jal_i(1'b0), .JalR_i(1'b0), .Branch_Target_i(32'h0), .JalR_Target_i(32'h0),
        .imem(mif2.master), .Instr_o(instr2), .Instr_Valid_o(ivalid2),
        .PC_o(pc2), .PC_Plus4_o(pc42), .Misaligned_o(mis2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC rule, straight from the redirect priority list.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic r_jalr,
                                             input logic r_jal, input logic r_br,
                                             input logic [31:0] r_bt, input logic [31:0] r_jt);
        if (r_jalr) return {r_jt[31:1], 1'b0};
        if (r_jal)  return r_bt;
        if (r_br)   return r_bt;
        return p + 32'd4;
    endfunction

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; br = 1'b0; jal = 1'b0; jalr = 1'b0;
        bt = '0; jt = '0;
        mif.Imem_Rvalid_i = 1'b0; mif.Imem_Rdata_i = '0;
        tick(); tick();
        n_cmp++; if (mif.Imem_Req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mif.Imem_Req_o); end
        n_cmp++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ivalid); end
        n_cmp++; if (mis !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", mis); end
        reset = 1'b0;
        m_pc = RST_PC;
        tick();
        n_cmp++; if (mif.Imem_Req_o !== 1'b1 || mif.Imem_Addr_o !== m_pc) begin
            n_fail++; $display("FAIL boot_req: got req=%b addr=%h want req=1 addr=%h", mif.Imem_Req_o, mif.Imem_Addr_o, m_pc);
        end
    endtask

    task automatic fetch(input logic [31:0] word, input int lat);
        for (int i = 0; i < lat; i++) begin
            tick();
            n_cmp++; if (mif.Imem_Req_o !== 1'b1 || mif.Imem_Addr_o !== m_pc || ivalid !== 1'b0) begin
                n_fail++; $display("FAIL req_wait: got req=%b addr=%h valid=%b want 1 %h 0", mif.Imem_Req_o, mif.Imem_Addr_o, ivalid, m_pc);
            end
        end
        mif.Imem_Rvalid_i = 1'b1;
        mif.Imem_Rdata_i  = word;
        tick();
        mif.Imem_Rvalid_i = 1'b0;
        mif.Imem_Rdata_i  = $urandom;
        m_instr = word;
        n_cmp++; if (ivalid !== 1'b1 || instr !== word || pc !== m_pc) begin
            n_fail++; $display("FAIL capture: got valid=%b instr=%h pc=%h want 1 %h %h", ivalid, instr, pc, word, m_pc);
        end
        n_cmp++; if (pc4 !== m_pc + 32'd4 || mif.Imem_Req_o !== 1'b0) begin
            n_fail++; $display("FAIL hold_pc4: got pc4=%h req=%b want %h 0", pc4, mif.Imem_Req_o, m_pc + 32'd4);
        end
    endtask

    task automatic retire(input logic r_jalr, input logic r_jal, input logic r_br,
                          input logic [31:0] r_bt, input logic [31:0] r_jt, input int stalls);
        logic [31:0] rnd;
        stall = 1'b1;
        for (int i = 0; i < stalls; i++) begin
            rnd = $urandom;
            jalr = rnd[0]; jal = rnd[1]; br = rnd[2]; bt = $urandom; jt = $urandom;
            tick();
            n_cmp++; if (ivalid !== 1'b1 || instr !== m_instr || pc !== m_pc || mif.Imem_Req_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold: got valid=%b instr=%h pc=%h req=%b want 1 %h %h 0", ivalid, instr, pc, mif.Imem_Req_o, m_instr, m_pc);
            end
        end
        stall = 1'b0;
        jalr = r_jalr; jal = r_jal; br = r_br; bt = r_bt; jt = r_jt;
        tick();
        jalr = 1'b0; jal = 1'b0; br = 1'b0;
        m_pc = ref_next(m_pc, r_jalr, r_jal, r_br, r_bt, r_jt);
        if (m_pc[1:0] == 2'b00) begin
            n_cmp++; if (mif.Imem_Req_o !== 1'b1 || mif.Imem_Addr_o !== m_pc || ivalid !== 1'b0 || mis !== 1'b0) begin
                n_fail++; $display("FAIL retire_addr: got req=%b addr=%h valid=%b mis=%b want 1 %h 0 0", mif.Imem_Req_o, mif.Imem_Addr_o, ivalid, mis, m_pc);
            end
        end else begin
            n_cmp++; if (mis !== 1'b1 || mif.Imem_Req_o !== 1'b0 || pc !== m_pc || ivalid !== 1'b0) begin
                n_fail++; $display("FAIL retire_trap: got mis=%b req=%b pc=%h valid=%b want 1 0 %h 0", mis, mif.Imem_Req_o, pc, ivalid, m_pc);
            end
        end
    endtask

    task automatic test_first_fetch();
        test_reset();
        fetch(32'h0050_0093, 0);
        retire(1'b0, 1'b0, 1'b0, '0, '0, 0);
    endtask

    task automatic test_stall();
        fetch($urandom, 1);
        retire(1'b0, 1'b0, 1'b0, '0, '0, 4);
    endtask

    task automatic test_redirect();
        test_reset();
        fetch($urandom, 0); retire(1'b0, 1'b0, 1'b1, 32'h0040_0010, '0, 0);
        fetch($urandom, 0); retire(1'b0, 1'b1, 1'b0, 32'h0040_0100, '0, 0);
        fetch($urandom, 0); retire(1'b0, 1'b0, 1'b1, 32'h0040_0010, '0, 0);
        fetch($urandom, 0); retire(1'b1, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0201, 0);
        fetch($urandom, 0); retire(1'b0, 1'b0, 1'b1, 32'h0040_0010, '0, 0);
        fetch($urandom, 0); retire(1'b0, 1'b0, 1'b1, 32'h0040_0008, '0, 0);
    endtask

    task automatic test_random();
        logic [31:0] rnd, r_bt, r_jt;
        test_reset();
        for (int n = 0; n < 40; n++) begin
            fetch($urandom, $urandom_range(0, 3));
            rnd  = $urandom;
            r_bt = $urandom; r_bt[1:0] = 2'b00;
            r_jt = $urandom; r_jt[1] = 1'b0;
            retire(rnd[0] & rnd[3], rnd[1] & rnd[4], rnd[2], r_bt, r_jt, $urandom_range(0, 2));
        end
    endtask

    task automatic test_misalign();
        fetch($urandom, 0);
        retire(1'b0, 1'b0, 1'b1, 32'h0040_0102, '0, 0);
        for (int i = 0; i < 10; i++) begin
            mif.Imem_Rvalid_i = $urandom_range(0, 1);
            tick();
            n_cmp++; if (mis !== 1'b1 || mif.Imem_Req_o !== 1'b0 || pc !== 32'h0040_0102 || ivalid !== 1'b0) begin
                n_fail++; $display("FAIL trap_sticky: got mis=%b req=%b pc=%h valid=%b want 1 0 00400102 0", mis, mif.Imem_Req_o, pc, ivalid);
            end
        end
        mif.Imem_Rvalid_i = 1'b0;
        test_reset();
    endtask

    task automatic test_reset_mid_fetch();
        test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mif.Imem_Rvalid_i = 1'b1;
        mif.Imem_Rdata_i  = 32'hDEAD_BEEF;
        tick();
        mif.Imem_Rvalid_i = 1'b0;
        n_cmp++; if (ivalid !== 1'b0 || instr !== 32'h0 || mif.Imem_Req_o !== 1'b1 || mif.Imem_Addr_o !== RST_PC) begin
            n_fail++; $display("FAIL reset_mid_fetch: got valid=%b instr=%h req=%b addr=%h want 0 0 1 %h", ivalid, instr, mif.Imem_Req_o, mif.Imem_Addr_o, RST_PC);
        end
        m_pc = RST_PC;
        fetch(32'h1234_5678, 1);
        retire(1'b0, 1'b0, 1'b0, '0, '0, 0);
    endtask

    task automatic test_wrap();
        mif2.Imem_Rvalid_i = 1'b0; mif2.Imem_Rdata_i = '0;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        tick();
        n_cmp++; if (mif2.Imem_Req_o !== 1'b1 || mif2.Imem_Addr_o !== WRAP_PC) begin
            n_fail++; $display("FAIL wrap_boot: got req=%b addr=%h want 1 %h", mif2.Imem_Req_o, mif2.Imem_Addr_o, WRAP_PC);
        end
        mif2.Imem_Rvalid_i = 1'b1; mif2.Imem_Rdata_i = 32'h0000_0013;
        tick();
        mif2.Imem_Rvalid_i = 1'b0;
        n_cmp++; if (ivalid2 !== 1'b1 || pc42 !== 32'h0) begin
            n_fail++; $display("FAIL wrap_hold: got valid=%b pc4=%h want 1 00000000", ivalid2, pc42);
        end
        tick();
        n_cmp++; if (mif2.Imem_Req_o !== 1'b1 || mif2.Imem_Addr_o !== 32'h0 || mis2 !== 1'b0) begin
            n_fail++; $display("FAIL wrap_addr: got req=%b addr=%h mis=%b want 1 00000000 0", mif2.Imem_Req_o, mif2.Imem_Addr_o, mis2);
        end
    endtask

    initial begin
        rst2 = 1'b1;
        mif2.Imem_Rvalid_i = 1'b0; mif2.Imem_Rdata_i = '0;
        test_first_fetch();
        test_stall();
        test_redirect();
        test_misalign();
        test_reset_mid_fetch();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder. Owns the PC, requests words from instruction memory over a req/valid handshake, and holds the fetched instruction stable for the decoder (Instr_o[6:0] drives the decoder opcode input).
- Computes the next PC from the redirect controls produced downstream (branch-taken, JAL, JALR). Halts on a misaligned target.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- WIDTH, 32, PC/instruction/target width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall_i  input  1  downstream not ready; the held instruction does not retire.
- Branch_Taken_i  input  1  conditional branch resolved taken.
- Jal_i  input  1  current instruction is JAL.
- JalR_i  input  1  current instruction is JALR.
- Branch_Target_i  input  WIDTH  PC+imm, used for a taken branch and for JAL.
- JalR_Target_i  input  WIDTH  rs1+imm, used for JALR.
- Imem_Rdata_i  input  WIDTH  instruction word from memory.
- Imem_Rvalid_i  input  1  Imem_Rdata_i is valid this cycle.
- Imem_Req_o  output  1  fetch request.
- Imem_Addr_o  output  WIDTH  fetch address (equals PC_o).
- Instr_o  output  WIDTH  held instruction.
- Instr_Valid_o  output  1  Instr_o is valid for decode.
- PC_o  output  WIDTH  PC of the held or requested instruction.
- PC_Plus4_o  output  WIDTH  PC_o+4, the link value for JAL/JALR.
- Misaligned_o  output  1  sticky fetch-misalign trap flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, and has priority over every other event, including mid-request. Memory shares this reset, so no stale responses exist.
- Reset values: state=BOOT, PC_o=RESET_PC, Instr_o=0, Instr_Valid_o=0, Imem_Req_o=0, Misaligned_o=0.
- All outputs are registered or decoded directly from state. No input-to-output combinational path.
- BOOT: Req=0. Next state is always REQ, one cycle later.
- REQ: Req=1 and Addr=PC_o, both held stable until Rvalid.
  - Rvalid=1: capture Rdata into Instr_o; next state HOLD.
  - Rvalid is legal no earlier than the cycle after Req first rises.
- HOLD: Instr_Valid_o=1 and Req=0.
  - Stall_i=1: remain in HOLD. Instr_o and PC_o are frozen, and redirect inputs are ignored.
  - Stall_i=0 (retire): compute next_pc, load it into PC_o, and clear Instr_Valid_o.
  - Retire goes to REQ if next_pc[1:0]==0, otherwise to TRAP.
- next_pc priority (highest first):
  - JalR_i: {JalR_Target_i[WIDTH-1:1],1'b0}.
  - Jal_i: Branch_Target_i.
  - Branch_Taken_i: Branch_Target_i.
  - Otherwise: PC_o+4.
- Simultaneous redirect flags resolve by this priority; no error is raised.
- Wrap-around: PC arithmetic is modulo 2^WIDTH. PC_o=32'hFFFF_FFFC with +4 gives 0, with no flag.
- TRAP:
  - Misaligned_o=1 (sticky). PC_o holds the offending target for the trap handler.
  - Req=0 and Instr_Valid_o=0.
  - Only reset exits TRAP.
- Rvalid outside REQ is ignored.
- Throughput: minimum 3 cycles per instruction with 1-cycle memory latency and no stall (REQ, REQ+Rvalid, HOLD/retire).
- PC_Plus4_o is always PC_o+4 (combinational adder on the PC register).

Decomposition:
- Shared package (rv_pkg): state encoding (BOOT/REQ/HOLD/TRAP, 2 bits), RESET_PC default, and opcode localparams (R/I/U/S/LW/JAL/JALR/B) shared with the decoder.
- One sub-module: next_pc_sel, purely combinational. Implements the priority mux plus JALR bit-0 clear plus misalign detect.
- fetch_unit holds the FSM, PC register and instruction register.

Test Plan:
1. Reset then 1-cycle memory. Expect Req rises the cycle after BOOT with Addr=32'h0040_0000. With Rdata=32'h0050_0093, expect Instr_o=32'h0050_0093, Valid=1 and PC_o=32'h0040_0000 one cycle later. With no stall, the next Req has Addr=32'h0040_0004.
2. Stall_i held 4 cycles in HOLD. Expect Instr_o and PC_o unchanged and Req=0 throughout, and redirect inputs toggled during the stall are ignored. After Stall_i falls: one retire, then Addr=PC+4.
3. Redirect at PC=32'h0040_0010:
   - Jal_i=1 with Branch_Target_i=32'h0040_0100: next Addr=32'h0040_0100.
   - JalR_i=1 together with Jal_i=1 and JalR_Target_i=32'h0040_0201: next Addr=32'h0040_0200 (JALR wins, bit 0 cleared).
   - Branch_Taken_i=1 alone with Branch_Target_i=32'h0040_0008: next Addr=32'h0040_0008.
4. Misalign: retire with Branch_Taken_i=1 and Branch_Target_i=32'h0040_0102. Expect TRAP, Misaligned_o=1 sticky, PC_o=32'h0040_0102, Req=0 for 10 cycles. Then reset: Misaligned_o=0 and PC_o=RESET_PC.
5. Reset mid-fetch: assert reset in REQ while Rvalid=0, then drive Rvalid=1 in the BOOT cycle. Expect the word ignored, Valid=0, then Req with Addr=RESET_PC.
6. Wrap: reset to PC=32'hFFFF_FFFC via the RESET_PC override and retire with no redirect. Expect next Addr=32'h0000_0000 and Misaligned_o=0.
